// File: rtl/jtag_axi_txn_ctrl.sv
// JTAG-side AXI4-Lite single-transaction master: one read or write per txn_start rising edge.
// Optional abort-on-timeout counter is built when JTAG_AXI_TIMEOUT_EN is defined.
module jtag_axi_txn_ctrl #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                  tck,
  input  logic                  trstn,
  input  logic                  txn_start,
  input  logic                  txn_rnw,
  input  logic [1:0]            txn_size,
  input  logic [ADDR_WIDTH-1:0] txn_addr,
  input  logic [DATA_WIDTH-1:0] txn_wdata,
  output logic                  txn_busy,
  output logic                  txn_done,
  output logic [2:0]            txn_status,
  output logic [DATA_WIDTH-1:0] txn_rdata,
  output logic                  m_awvalid,
  input  logic                  m_awready,
  output logic [ADDR_WIDTH-1:0] m_awaddr,
  output logic [2:0]            m_awsize,
  output logic [2:0]            m_awprot,
  output logic                  m_wvalid,
  input  logic                  m_wready,
  output logic [DATA_WIDTH-1:0] m_wdata,
  output logic [3:0]            m_wstrb,
  input  logic                  m_bvalid,
  output logic                  m_bready,
  input  logic [1:0]            m_bresp,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  output logic [ADDR_WIDTH-1:0] m_araddr,
  output logic [2:0]            m_arsize,
  output logic [2:0]            m_arprot,
  input  logic                  m_rvalid,
  output logic                  m_rready,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic [1:0]            m_rresp
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP} state_t;

  state_t                state_q, state_d;
  logic                  start_q;
  logic                  aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic                  awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d;
  logic [ADDR_WIDTH-1:0] awaddr_d, araddr_d;
  logic [2:0]            awsize_d, arsize_d, status_d;
  logic [DATA_WIDTH-1:0] wdata_d, rdata_d;
  logic [3:0]            wstrb_d;
  logic                  busy_d, done_d;
  logic                  start_edge, aw_hs, w_hs, timeout_hit;
  logic [2:0]            size_axi;
  logic [3:0]            strb_new;

  assign m_awprot   = '0;
  assign m_arprot   = '0;
  assign start_edge = txn_start & ~start_q;
  assign aw_hs      = m_awvalid & m_awready;
  assign w_hs       = m_wvalid & m_wready;
  assign size_axi   = (txn_size == 2'd3) ? 3'd2 : {1'b0, txn_size};

  always_comb begin
    strb_new = 4'hF;
    case (txn_size)
      2'd0:    strb_new = 4'b0001 << txn_addr[1:0];
      2'd1:    strb_new = 4'b0011 << {txn_addr[1], 1'b0};
      default: strb_new = 4'hF;
    endcase
  end

  function automatic logic [2:0] resp_status(input logic [1:0] resp);
    case (resp)
      2'b10:   return 3'd1;
      2'b11:   return 3'd2;
      default: return 3'd0;
    endcase
  endfunction

`ifdef JTAG_AXI_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge tck) begin
    if (!trstn || state_q == IDLE) cnt_q <= '0;
    else                           cnt_q <= cnt_q + 1'b1;
  end

  // >= so a timeout pre-empted by a handshake still fires in the next state
  assign timeout_hit = (state_q != IDLE) && (cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    awvalid_d = m_awvalid;
    wvalid_d  = m_wvalid;
    bready_d  = m_bready;
    arvalid_d = m_arvalid;
    rready_d  = m_rready;
    awaddr_d  = m_awaddr;
    araddr_d  = m_araddr;
    awsize_d  = m_awsize;
    arsize_d  = m_arsize;
    wdata_d   = m_wdata;
    wstrb_d   = m_wstrb;
    rdata_d   = txn_rdata;
    status_d  = txn_status;
    busy_d    = txn_busy;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_edge) begin
          busy_d    = 1'b1;
          status_d  = 3'd4;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (txn_rnw) begin
            state_d   = RD_REQ;
            arvalid_d = 1'b1;
            araddr_d  = txn_addr;
            arsize_d  = size_axi;
          end else begin
            state_d   = WR_REQ;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            awaddr_d  = txn_addr;
            awsize_d  = size_axi;
            wdata_d   = txn_wdata;
            wstrb_d   = strb_new;
          end
        end
      end
      WR_REQ: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
          state_d  = WR_RESP;
          bready_d = 1'b1;
        end
      end
      WR_RESP: begin
        if (m_bvalid) begin
          state_d  = IDLE;
          bready_d = 1'b0;
          status_d = resp_status(m_bresp);
          busy_d   = 1'b0;
          done_d   = 1'b1;
        end
      end
      RD_REQ: begin
        if (m_arready) begin
          state_d   = RD_RESP;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      RD_RESP: begin
        if (m_rvalid) begin
          state_d  = IDLE;
          rready_d = 1'b0;
          rdata_d  = m_rdata;
          status_d = resp_status(m_rresp);
          busy_d   = 1'b0;
          done_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // abort only when no handshake moved the FSM this cycle
    if (timeout_hit && state_d == state_q) begin
      state_d   = IDLE;
      awvalid_d = 1'b0;
      wvalid_d  = 1'b0;
      bready_d  = 1'b0;
      arvalid_d = 1'b0;
      rready_d  = 1'b0;
      status_d  = 3'd3;
      busy_d    = 1'b0;
      done_d    = 1'b1;
    end
  end

  always_ff @(posedge tck) begin
    if (!trstn) begin
      state_q    <= IDLE;
      start_q    <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      m_awvalid  <= 1'b0;
      m_wvalid   <= 1'b0;
      m_bready   <= 1'b0;
      m_arvalid  <= 1'b0;
      m_rready   <= 1'b0;
      m_awaddr   <= '0;
      m_araddr   <= '0;
      m_awsize   <= '0;
      m_arsize   <= '0;
      m_wdata    <= '0;
      m_wstrb    <= '0;
      txn_rdata  <= '0;
      txn_status <= '0;
      txn_busy   <= 1'b0;
      txn_done   <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_q    <= txn_start;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      m_awvalid  <= awvalid_d;
      m_wvalid   <= wvalid_d;
      m_bready   <= bready_d;
      m_arvalid  <= arvalid_d;
      m_rready   <= rready_d;
      m_awaddr   <= awaddr_d;
      m_araddr   <= araddr_d;
      m_awsize   <= awsize_d;
      m_arsize   <= arsize_d;
      m_wdata    <= wdata_d;
      m_wstrb    <= wstrb_d;
      txn_rdata  <= rdata_d;
      txn_status <= status_d;
      txn_busy   <= busy_d;
      txn_done   <= done_d;
    end
  end

endmodule

// File: tb/tb_jtag_axi_txn_ctrl.sv
// Directed self-checking bench for jtag_axi_txn_ctrl; the slave side is driven step by step.
module tb_jtag_axi_txn_ctrl;

  logic        tck = 1'b0;
  logic        trstn;
  logic        txn_start, txn_rnw;
  logic [1:0]  txn_size;
  logic [31:0] txn_addr, txn_wdata;
  logic        txn_busy, txn_done;
  logic [2:0]  txn_status;
  logic [31:0] txn_rdata;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;
  logic [31:0] m_awaddr, m_araddr, m_wdata, m_rdata;
  logic [2:0]  m_awsize, m_awprot, m_arsize, m_arprot;
  logic [3:0]  m_wstrb;
  logic [1:0]  m_bresp, m_rresp;

  int checks = 0;
  int errors = 0;
  int n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0, n_done = 0;
  logic [31:0] exp_rdata;

  always #5 tck = ~tck;

  jtag_axi_txn_ctrl #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .tck(tck), .trstn(trstn),
    .txn_start(txn_start), .txn_rnw(txn_rnw), .txn_size(txn_size),
    .txn_addr(txn_addr), .txn_wdata(txn_wdata),
    .txn_busy(txn_busy), .txn_done(txn_done), .txn_status(txn_status), .txn_rdata(txn_rdata),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
    .m_awsize(m_awsize), .m_awprot(m_awprot),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
    .m_arsize(m_arsize), .m_arprot(m_arprot),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp)
  );

  always @(posedge tck) begin
    if (trstn) begin
      if (m_awvalid && m_awready) n_aw++;
      if (m_wvalid && m_wready)   n_w++;
      if (m_bvalid && m_bready)   n_b++;
      if (m_arvalid && m_arready) n_ar++;
      if (m_rvalid && m_rready)   n_r++;
      if (txn_done)               n_done++;
    end
  end

  task automatic tick();
    @(posedge tck);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    trstn = 1'b0; txn_start = 1'b0; txn_rnw = 1'b0; txn_size = 2'd0;
    txn_addr = '0; txn_wdata = '0;
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = 2'b00;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = 2'b00;
    tick(); tick();
    chk("rst_ctrl", {txn_busy, txn_done, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, 0);
    chk("rst_status", txn_status, 0);
    chk("rst_rdata", txn_rdata, 0);
    chk("rst_addr_strb", {m_awaddr, m_wstrb}, 0);
    trstn = 1'b1;
    tick();

    // word write, slave ready immediately
    txn_rnw = 1'b0; txn_size = 2'd2; txn_addr = 32'h1000_0004; txn_wdata = 32'hDEAD_BEEF;
    m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b1; m_bresp = 2'b00;
    txn_start = 1'b1;
    tick();
    chk("wr1_valids", {m_awvalid, m_wvalid}, 2'b11);
    chk("wr1_strb", m_wstrb, 4'hF);
    chk("wr1_addr", m_awaddr, 32'h1000_0004);
    chk("wr1_wdata", m_wdata, 32'hDEAD_BEEF);
    chk("wr1_size_prot", {m_awsize, m_awprot}, {3'd2, 3'd0});
    chk("wr1_busy_status", {txn_busy, txn_status}, {1'b1, 3'd4});
    tick();
    chk("wr1_resp_phase", {m_bready, m_awvalid, m_wvalid, txn_done}, 4'b1000);
    tick();
    chk("wr1_done", {txn_done, txn_busy, m_bready}, 3'b100);
    chk("wr1_status", txn_status, 3'd0);
    txn_start = 1'b0; m_bvalid = 1'b0;
    tick();
    chk("wr1_done_pulse", txn_done, 1'b0);
    chk("wr1_counts", {n_aw[7:0], n_w[7:0], n_b[7:0], n_done[7:0]}, 32'h01010101);
    chk("wr1_rdata_held", txn_rdata, 32'h0);

    // byte read with SLVERR
    txn_rnw = 1'b1; txn_size = 2'd0; txn_addr = 32'h2000_0003;
    m_arready = 1'b1; m_rvalid = 1'b1; m_rdata = 32'h1122_3344; m_rresp = 2'b10;
    txn_start = 1'b1;
    tick();
    chk("rd1_arvalid", m_arvalid, 1'b1);
    chk("rd1_araddr", m_araddr, 32'h2000_0003);
    chk("rd1_size_prot", {m_arsize, m_arprot}, {3'd0, 3'd0});
    chk("rd1_busy_status", {txn_busy, txn_status}, {1'b1, 3'd4});
    tick();
    chk("rd1_resp_phase", {m_arvalid, m_rready, txn_busy, txn_done}, 4'b0110);
    tick();
    chk("rd1_done", {txn_done, txn_busy, m_rready}, 3'b100);
    chk("rd1_status", txn_status, 3'd1);
    chk("rd1_rdata", txn_rdata, 32'h1122_3344);
    txn_start = 1'b0; m_rvalid = 1'b0; m_arready = 1'b0; m_rdata = 32'hFFFF_FFFF;
    tick();
    chk("rd1_counts", {n_ar[7:0], n_r[7:0], n_done[7:0]}, 24'h010102);
    chk("rd1_rdata_held", txn_rdata, 32'h1122_3344);

    // byte write, wready late; DECERR response
    txn_rnw = 1'b0; txn_size = 2'd0; txn_addr = 32'h3000_0002; txn_wdata = 32'h0000_00AB;
    m_awready = 1'b1; m_wready = 1'b0; m_bvalid = 1'b0;
    txn_start = 1'b1;
    tick();
    chk("wr2_c1_valids", {m_awvalid, m_wvalid}, 2'b11);
    chk("wr2_strb", m_wstrb, 4'b0100);
    for (int i = 2; i <= 4; i++) begin
      tick();
      chk("wr2_w_held", {m_awvalid, m_wvalid, m_bready}, 3'b010);
    end
    m_wready = 1'b1;
    tick();
    chk("wr2_c5", {m_awvalid, m_wvalid, m_bready}, 3'b001);
    m_wready = 1'b0;
    tick();
    chk("wr2_b_wait", {m_bready, txn_done, txn_busy}, 3'b101);
    m_bvalid = 1'b1; m_bresp = 2'b11;
    tick();
    chk("wr2_done_status", {txn_done, txn_status}, {1'b1, 3'd2});
    m_bvalid = 1'b0; txn_start = 1'b0;
    tick();
    chk("wr2_counts", {n_aw[7:0], n_w[7:0], n_b[7:0], n_done[7:0]}, 32'h02020203);
    chk("wr2_rdata_held", txn_rdata, 32'h1122_3344);

    // read; a second start edge during RD_RESP must be ignored
    txn_rnw = 1'b1; txn_size = 2'd3; txn_addr = 32'h5000_0010;
    m_arready = 1'b1; m_rvalid = 1'b0;
    txn_start = 1'b1;
    tick();
    chk("rd2_arsize", m_arsize, 3'd2);
    tick();
    chk("rd2_rready", m_rready, 1'b1);
    txn_start = 1'b0;
    tick();
    txn_start = 1'b1;
    tick();
    chk("rd2_ignored_edge", {txn_busy, txn_status, m_arvalid}, {1'b1, 3'd4, 1'b0});
    m_rvalid = 1'b1; m_rdata = 32'hA5A5_5A5A; m_rresp = 2'b00;
    tick();
    chk("rd2_done", {txn_done, txn_status}, {1'b1, 3'd0});
    chk("rd2_rdata", txn_rdata, 32'hA5A5_5A5A);
    m_rvalid = 1'b0; m_arready = 1'b0;
    tick(); tick();
    chk("rd2_no_relaunch", {txn_busy, m_arvalid, txn_done}, 3'b000);
    chk("rd2_counts", {n_ar[7:0], n_done[7:0]}, 16'h0204);
    txn_start = 1'b0;
    tick();

    // read with arready never asserted
    exp_rdata = 32'hA5A5_5A5A;
    txn_rnw = 1'b1; txn_size = 2'd2; txn_addr = 32'h6000_0000;
    txn_start = 1'b1;
    tick();
    chk("to_start", {txn_busy, m_arvalid}, 2'b11);
    for (int i = 2; i <= 16; i++) tick();
    chk("to_busy16", {txn_busy, txn_done, txn_status}, {2'b10, 3'd4});
    tick();
`ifdef JTAG_AXI_TIMEOUT_EN
    chk("to_abort", {txn_done, txn_busy, m_arvalid}, 3'b100);
    chk("to_status", txn_status, 3'd3);
`else
    chk("to_waiting", {txn_done, txn_busy, m_arvalid}, 3'b011);
    chk("to_status_run", txn_status, 3'd4);
    m_arready = 1'b1;
    tick();
    m_arready = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h0BAD_F00D; m_rresp = 2'b01;
    exp_rdata = 32'h0BAD_F00D;
    tick();
    chk("to_late_done", {txn_done, txn_status}, {1'b1, 3'd0});
    m_rvalid = 1'b0;
`endif
    chk("to_rdata", txn_rdata, exp_rdata);
    txn_start = 1'b0;
    tick();
    chk("to_done_count", n_done, 5);

    // reset while in WR_RESP, start held high across reset
    txn_rnw = 1'b0; txn_size = 2'd1; txn_addr = 32'h4000_0003; txn_wdata = 32'h1234_5678;
    m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b0;
    txn_start = 1'b1;
    tick();
    chk("rs_strb_half", {m_wstrb, m_awsize}, {4'b1100, 3'd1});
    tick();
    chk("rs_bready", m_bready, 1'b1);
    trstn = 1'b0; m_bvalid = 1'b1;
    tick();
    chk("rs_abandon", {m_bready, txn_busy, txn_done, txn_status}, 6'b0);
    chk("rs_clear", {m_wstrb, txn_rdata}, 36'h0);
    trstn = 1'b1; m_bvalid = 1'b0;
    tick();
    chk("rs_relaunch", {txn_busy, m_awvalid, m_wvalid, txn_status}, {3'b111, 3'd4});
    chk("rs_relaunch_strb", m_wstrb, 4'b1100);
    chk("rs_no_done", {n_done[7:0], n_b[7:0]}, 16'h0502);
    tick();
    m_bvalid = 1'b1; m_bresp = 2'b01;
    tick();
    chk("rs_done", {txn_done, txn_busy, txn_status}, {2'b10, 3'd0});
    m_bvalid = 1'b0; txn_start = 1'b0;
    tick();
    chk("rs_counts", {n_done[7:0], n_b[7:0]}, 16'h0603);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
